// File: rtl/asu_result_fifo.sv
// ---------------------------------------------------------------------------
// asu_result_fifo
//
// Purpose:
//   Output buffer behind the asu datapath. Each asu result ({carry, out}) and
//   the mode tag it was produced with go into a DEPTH-entry FIFO. The consumer
//   reads them over a valid/ready handshake, so a stalling consumer does not
//   throttle asu issue until the FIFO fills. The block also keeps a saturating
//   count of accepted results that had carry=1.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2). Pointers wrap naturally at DEPTH.
//   DATA_W  width of the asu out field
//   CNT_W   width of carry_cnt
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   asu result valid this cycle
//   in_carry   in   asu carry
//   in_out     in   asu out [DATA_W]
//   in_mode    in   mode tag for this result
//   in_ready   out  FIFO can accept (push = in_valid & in_ready)
//   out_valid  out  head entry available
//   out_data   out  {carry, out} of head entry [DATA_W+1], zero when !out_valid
//   out_mode   out  mode of head entry, zero when !out_valid
//   out_ready  in   consumer accepts (pop = out_valid & out_ready)
//   level      out  occupancy 0..DEPTH [$clog2(DEPTH)+1]
//   carry_cnt  out  accepted pushes with carry=1, saturating [CNT_W]
//
// Build option:
//   ASU_FIFO_BYPASS_EN  when defined, a result arriving at an empty FIFO while
//                       the consumer is ready goes straight to the output in
//                       the same cycle and is never written to storage.
//                       Undefined (default): no combinational in->out path.
// ---------------------------------------------------------------------------
module asu_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_carry,
    input  logic [DATA_W-1:0]        in_out,
    input  logic                     in_mode,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W:0]          out_data,
    output logic                     out_mode,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         carry_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic              mode;
        logic              carry;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Storage is deliberately not reset; occupancy alone says what is live.
    entry_t             mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q,  level_d;
    logic [CNT_W-1:0]   carry_cnt_q, carry_cnt_d;

    logic   empty, full;
    logic   push_hs;   // input handshake completed this cycle
    logic   bypass;    // accepted result goes straight to the consumer
    logic   wr_en;     // write into storage
    logic   rd_en;     // retire the stored head entry
    entry_t in_entry;
    entry_t head;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign in_entry = '{mode: in_mode, carry: in_carry, data: in_out};
    assign head     = mem_q[rd_ptr_q];

    // Acceptance never looks at out_ready: a full FIFO refuses even if the
    // consumer is draining an entry in the same cycle.
    assign in_ready = ~reset & ~full;
    assign push_hs  = in_valid & in_ready;

`ifdef ASU_FIFO_BYPASS_EN
    // Only from an empty FIFO, otherwise ordering would break.
    assign bypass = ~reset & empty & in_valid & out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result is consumed directly and never touches storage.
    assign wr_en = push_hs & ~bypass;
    assign rd_en = ~reset & ~empty & out_ready;

    // -----------------------------------------------------------------------
    // Consumer side. Outputs are forced to zero whenever nothing is valid so
    // stale storage contents never leak out.
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_mode  = 1'b0;
        if (!reset) begin
            if (!empty) begin
                out_valid = 1'b1;
                out_data  = {head.carry, head.data};
                out_mode  = head.mode;
            end else if (bypass) begin
                out_valid = 1'b1;
                out_data  = {in_carry, in_out};
                out_mode  = in_mode;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state: pointers, occupancy, carry counter.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        carry_cnt_d = carry_cnt_q;

        // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Counts every accepted carry=1 result, bypassed ones included.
        if (push_hs && in_carry && (carry_cnt_q != '1))
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            carry_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    // wr_en is already gated by reset through in_ready.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_entry;
    end

    assign level     = level_q;
    assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_asu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_asu_result_fifo
//
// Scoreboard bench for asu_result_fifo (DEPTH=4, DATA_W=8, CNT_W=8).
// The reference model is a plain queue of accepted results plus an integer
// carry counter. A recorder process (negedge) decides from the model what the
// DUT must show this cycle and pushes accepted results; a monitor process
// (negedge + 1) compares the DUT outputs and pops the queue on each transfer.
// Inputs are driven 1 time unit after each posedge.
// ---------------------------------------------------------------------------
module tb_asu_result_fifo;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ASU_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_carry, in_mode, out_ready;
    logic [DATA_W-1:0] in_out;
    logic              in_ready, out_valid, out_mode;
    logic [DATA_W:0]   out_data;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]  carry_cnt;

    asu_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_carry  (in_carry),
        .in_out    (in_out),
        .in_mode   (in_mode),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_ready (out_ready),
        .level     (level),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Model: accepted-but-not-yet-consumed results, {mode, carry, out}.
    logic [DATA_W+1:0] sb[$];
    int                model_cnt = 0;

    // What the DUT must present during the current cycle.
    bit              e_valid, e_ready, e_mode;
    int              e_lvl, e_cnt;
    logic [DATA_W:0] e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Recorder: model the cycle from the current inputs and model state.
    always @(negedge clk) begin
        int lvl;
        lvl     = sb.size();
        e_lvl   = lvl;
        e_cnt   = model_cnt;
        e_ready = !reset && (lvl != DEPTH);
        e_valid = !reset && ((lvl != 0) || (BYP && in_valid && out_ready));
        if (reset) begin
            sb.delete();
            model_cnt = 0;
        end else if (in_valid && e_ready) begin
            sb.push_back({in_mode, in_carry, in_out});
            if (in_carry && model_cnt < CNT_MAX) model_cnt++;
        end
        // With bypass the freshly accepted result is also the head.
        if (e_valid) {e_mode, e_data} = sb[0];
        else begin
            e_mode = 1'b0;
            e_data = '0;
        end
    end

    // Monitor: compare DUT against the model, retire transferred entries.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("level",     32'(level),     32'(e_lvl));
            check("carry_cnt", 32'(carry_cnt), 32'(e_cnt));
            check("in_ready",  32'(in_ready),  32'(e_ready));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("out_data",  32'(out_data),  32'(e_data));
            check("out_mode",  32'(out_mode),  32'(e_mode));
        end
        if (e_valid && out_ready) void'(sb.pop_front());
    end

    task automatic cyc(input bit v, input bit c, input logic [DATA_W-1:0] d,
                       input bit m, input bit r);
        in_valid  = v;
        in_carry  = c;
        in_out    = d;
        in_mode   = m;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        // Reset held two cycles; the second one is checked.
        cyc(0, 0, 8'h00, 0, 0);
        chk_en = 1'b1;
        cyc(0, 0, 8'h00, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 8'h00, 0, 0);

        // Single pass.
        cyc(1, 1, 8'hA5, 0, 1);
        cyc(0, 0, 8'h00, 0, 1);
        cyc(0, 0, 8'h00, 0, 1);

        // Fill/stall: fifth push is refused while full.
        for (int i = 1; i <= 5; i++) cyc(1, 0, DATA_W'(i), i[0], 0);
        for (int i = 0; i < 5; i++)  cyc(0, 0, 8'h00, 0, 1);

        // Wrap with simultaneous push and pop at level 2.
        cyc(1, 0, 8'h10, 0, 0);
        cyc(1, 1, 8'h11, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, i[0], DATA_W'(8'h20 + i), i[1], 1);
        for (int i = 0; i < 3; i++)  cyc(0, 0, 8'h00, 0, 1);

        // Reset mid-operation: three entries must vanish.
        for (int i = 0; i < 3; i++) cyc(1, 1, DATA_W'(8'h30 + i), 0, 0);
        reset = 1'b1;
        cyc(1, 1, 8'h3F, 1, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1);

        // Carry counter saturation.
        for (int i = 0; i < CNT_MAX + 6; i++) cyc(1, 1, DATA_W'(i), i[0], 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                DATA_W'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) != 0);

        // Drain: every accepted entry must have come out exactly once.
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(0, 0, 8'h00, 0, 1);
        check("drain_empty", 32'(sb.size()), 32'd0);
        cyc(0, 0, 8'h00, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
